// File: rtl/game_life_pkg.sv
// Shared board-memory types and defaults for the Game of Life board arbiter.
package game_life_pkg;

  localparam int unsigned BOARD_ADDR_W   = 11;
  localparam int unsigned STARVE_MAX_DEF = 7;
  localparam int unsigned STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_ENG  = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the engine waited without a grant.
module arb_starve_ctr
  import game_life_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    eng_req_i,
  input  logic                    eng_gnt_i,
  output logic [STARVE_CNT_W-1:0] cnt_o
);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!eng_req_i || eng_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q < STARVE_CNT_W'(STARVE_MAX)) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board memory arbiter: display reads have priority over engine accesses.
// Optional BOARD_ARB_STARVE_GUARD_EN lets a starved engine preempt the display for one cycle.
module board_mem_arbiter
  import game_life_pkg::*;
#(
  parameter int unsigned ADDR_W     = BOARD_ADDR_W,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic              disp_rdata,
  output logic              disp_drop,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic              eng_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wdata,
  input  logic              mem_rdata
);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    sel_disp;
  logic                    sel_eng;
  owner_e                  own_q, own_d;

`ifdef BOARD_ARB_STARVE_GUARD_EN
  logic starve_hit;
  assign starve_hit = eng_req && (starve_cnt == STARVE_CNT_W'(STARVE_MAX));
`else
  logic unused_starve;
  assign unused_starve = ^starve_cnt;
`endif

  // Arbitration decision; everything is held quiet while in reset.
  always_comb begin
    sel_disp = 1'b0;
    sel_eng  = 1'b0;
    if (rst_n) begin
`ifdef BOARD_ARB_STARVE_GUARD_EN
      if (starve_hit)    sel_eng  = 1'b1;
      else if (disp_req) sel_disp = 1'b1;
      else if (eng_req)  sel_eng  = 1'b1;
`else
      if (disp_req)      sel_disp = 1'b1;
      else if (eng_req)  sel_eng  = 1'b1;
`endif
    end
  end

  always_comb begin
    mem_en    = sel_disp | sel_eng;
    mem_we    = sel_eng & eng_we;
    mem_wdata = sel_eng & eng_wdata;
    mem_addr  = '0;
    if (sel_disp)     mem_addr = disp_addr;
    else if (sel_eng) mem_addr = eng_addr;
  end

  assign eng_gnt = sel_eng;

`ifdef BOARD_ARB_STARVE_GUARD_EN
  assign disp_drop = rst_n & disp_req & ~sel_disp;
`else
  assign disp_drop = 1'b0;
`endif

  // Owner tag of the read issued this cycle; writes leave no tag.
  always_comb begin
    own_d = OWN_NONE;
    if (sel_disp)              own_d = OWN_DISP;
    else if (sel_eng && !eng_we) own_d = OWN_ENG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) own_q <= OWN_NONE;
    else        own_q <= own_d;
  end

  assign disp_rvalid = rst_n && (own_q == OWN_DISP);
  assign eng_rvalid  = rst_n && (own_q == OWN_ENG);
  assign disp_rdata  = disp_rvalid & mem_rdata;
  assign eng_rdata   = eng_rvalid & mem_rdata;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .eng_req_i (eng_req),
    .eng_gnt_i (sel_eng),
    .cnt_o     (starve_cnt)
  );

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Randomized bench for board_mem_arbiter against a cycle-level behavioural model.
module tb_board_mem_arbiter;

  localparam int unsigned AW   = 11;
  localparam int unsigned SMAX = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_rvalid, disp_rdata, disp_drop;
  logic          eng_req = 1'b0;
  logic          eng_we = 1'b0;
  logic [AW-1:0] eng_addr = '0;
  logic          eng_wdata = 1'b0;
  logic          eng_gnt, eng_rvalid, eng_rdata;
  logic          mem_en, mem_we, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rdata = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: who owns the read in flight (0 none, 1 display, 2 engine) and wait count.
  int unsigned pend = 0;
  int unsigned cnt  = 0;

  board_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid),
    .disp_rdata(disp_rdata), .disp_drop(disp_drop),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check at the falling edge, advance the model.
  task automatic step(input logic dr, input logic [AW-1:0] da, input logic er, input logic ew,
                      input logic [AW-1:0] ea, input logic ed, input logic rd,
                      input bit rst_after, output bit granted);
    bit force_eng;
    bit dsrv;
    bit esrv;
    bit drop;
    logic [AW-1:0] exp_addr;
    disp_req = dr; disp_addr = da;
    eng_req = er; eng_we = ew; eng_addr = ea; eng_wdata = ed;
    mem_rdata = rd;
    @(negedge clk);
    force_eng = 1'b0;
`ifdef BOARD_ARB_STARVE_GUARD_EN
    force_eng = er && (cnt == SMAX);
`endif
    dsrv = rst_n && dr && !force_eng;
    esrv = rst_n && er && !dsrv;
    drop = 1'b0;
`ifdef BOARD_ARB_STARVE_GUARD_EN
    drop = rst_n && dr && !dsrv;
`endif
    exp_addr = dsrv ? da : (esrv ? ea : '0);
    check_eq("mem_en",      32'(mem_en),      32'(dsrv || esrv));
    check_eq("mem_we",      32'(mem_we),      32'(esrv && ew));
    check_eq("mem_addr",    32'(mem_addr),    32'(exp_addr));
    check_eq("mem_wdata",   32'(mem_wdata),   32'(esrv && ed));
    check_eq("eng_gnt",     32'(eng_gnt),     32'(esrv));
    check_eq("disp_drop",   32'(disp_drop),   32'(drop));
    check_eq("disp_rvalid", 32'(disp_rvalid), 32'(rst_n && pend == 1));
    check_eq("disp_rdata",  32'(disp_rdata),  32'(rst_n && pend == 1 && rd));
    check_eq("eng_rvalid",  32'(eng_rvalid),  32'(rst_n && pend == 2));
    check_eq("eng_rdata",   32'(eng_rdata),   32'(rst_n && pend == 2 && rd));
    check_eq("starve_cnt",  32'(dut.u_starve.cnt_q), cnt);
    granted = esrv;
    if (rst_n && !rst_after) begin
      pend = dsrv ? 1 : ((esrv && !ew) ? 2 : 0);
      cnt  = (er && !esrv) ? ((cnt < SMAX) ? cnt + 1 : cnt) : 0;
    end else begin
      pend = 0;
      cnt  = 0;
    end
    if (rst_after) rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit g;
    bit e_act;
    bit e_we, e_wd;
    logic [AW-1:0] e_addr;
    logic [AW-1:0] r_addr;

    // Outputs quiet while held in reset, even with requests present.
    repeat (3) step(1'b1, 11'h040, 1'b1, 1'b0, 11'h123, 1'b1, 1'b1, 1'b0, g);
    rst_n = 1'b1;

    // Display read; data returns next cycle.
    step(1'b1, 11'h040, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, g);
    step(1'b0, '0,      1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, g);
    // Engine write to the top cell: granted, no read data.
    step(1'b0, '0, 1'b1, 1'b1, 11'h7FF, 1'b1, 1'b0, 1'b0, g);
    step(1'b0, '0, 1'b0, 1'b0, '0,      1'b0, 1'b1, 1'b0, g);
    // Contention: display wins for three cycles, engine read served when display stops.
    repeat (3) step(1'b1, 11'h055, 1'b1, 1'b0, 11'h2AA, 1'b0, 1'b1, 1'b0, g);
    step(1'b0, '0, 1'b1, 1'b0, 11'h2AA, 1'b0, 1'b0, 1'b0, g);
    step(1'b0, '0, 1'b0, 1'b0, '0,      1'b0, 1'b1, 1'b0, g);
    // Sustained contention exercises saturation and, if enabled, the starvation guard.
    repeat (20) step(1'b1, 11'h011, 1'b1, 1'b0, 11'h3C3, 1'b1, 1'b1, 1'b0, g);
    // Idle.
    repeat (10) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, g);
    // Reset lands after a display read is issued: the read is discarded.
    step(1'b1, 11'h100, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, g);
    repeat (2) step(1'b1, 11'h100, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, g);
    rst_n = 1'b1;
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, g);

    // Random traffic; the engine holds its request until granted.
    e_act = 1'b0; e_we = 1'b0; e_wd = 1'b0; e_addr = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!e_act && ($urandom_range(0, 1) == 1)) begin
        e_act  = 1'b1;
        e_we   = 1'($urandom_range(0, 1));
        e_wd   = 1'($urandom_range(0, 1));
        e_addr = AW'($urandom);
      end
      r_addr = AW'($urandom);
      step(1'($urandom_range(0, 9) < 7), r_addr, e_act, e_we, e_addr, e_wd,
           1'($urandom_range(0, 1)), (i == 700), g);
      if (g) e_act = 1'b0;
      if (!rst_n) begin
        e_act = 1'b0;
        step(1'b1, r_addr, 1'b1, 1'b0, e_addr, 1'b0, 1'b1, 1'b0, g);
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, board cell address width (64x32 board).
REQ-002 SHALL have parameter STARVE_MAX, default 7, the maximum number of consecutive engine denials before forced service; legal range 1..15.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have the display port: disp_req in 1 (read request); disp_addr in ADDR_W; disp_rvalid out 1; disp_rdata out 1; disp_drop out 1 (request not served this cycle).
REQ-005 SHALL have the engine port: eng_req in 1; eng_we in 1; eng_addr in ADDR_W; eng_wdata in 1; eng_gnt out 1; eng_rvalid out 1; eng_rdata out 1.
REQ-006 SHALL have the memory port: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out 1; mem_rdata in 1 (valid one cycle after a read enable).

Function
REQ-007 SHALL issue at most one memory access per cycle; mem_* is combinational from the current-cycle arbitration decision.
REQ-008 SHALL give the display priority: disp_req=1 -> mem_en=1, mem_we=0, mem_addr=disp_addr, eng_gnt=0.
REQ-009 SHALL grant the engine (eng_gnt=1, same cycle) when eng_req=1 and the display is not selected; mem_we=eng_we, mem_addr=eng_addr, mem_wdata=eng_wdata.
REQ-010 SHALL require the engine to hold eng_req/eng_we/eng_addr/eng_wdata stable until eng_gnt=1; each eng_gnt cycle completes exactly one access.
REQ-011 SHALL drive mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 when neither requester is selected.
REQ-012 SHALL record a registered owner tag (NONE/DISP/ENG) for each read; one cycle later SHALL pulse disp_rvalid or eng_rvalid for exactly one cycle, with the matching rdata=mem_rdata.
REQ-013 SHALL hold disp_rdata/eng_rdata at 0 whenever their rvalid is 0.
REQ-014 SHALL NOT raise eng_rvalid for an engine write.
REQ-015 SHALL keep a 4-bit starvation counter: +1 on each cycle with eng_req=1 and eng_gnt=0, saturating at STARVE_MAX; cleared on eng_gnt=1 or eng_req=0.
REQ-016 SHALL pulse disp_drop=1 for one cycle when disp_req=1 is not served; no disp_rvalid follows that request.
REQ-017 SHALL, on simultaneous requests with the counter below STARVE_MAX, serve the display.

Reset
REQ-018 SHALL, while rst_n=0, clear the owner tag and starvation counter and drive every output to 0, independently of clk.
REQ-019 SHALL discard any read issued in the cycle before reset asserts; no rvalid appears after reset release for it.
REQ-020 SHALL accept requests on the first rising clk edge after rst_n deasserts.

Configuration
REQ-021 SHALL honour macro BOARD_ARB_STARVE_GUARD_EN: when defined, eng_req=1 with counter==STARVE_MAX wins over disp_req for one cycle (disp_drop=1, counter clears).
REQ-022 SHALL, without BOARD_ARB_STARVE_GUARD_EN, use strict display priority; disp_drop is tied 0, and the counter still saturates but never forces a grant.

Structure
REQ-023 SHALL take the default ADDR_W, the owner-tag enumeration (OWN_NONE, OWN_DISP, OWN_ENG) and the default STARVE_MAX from the shared package game_life_pkg.
REQ-024 SHALL place the saturating starvation counter in one sub-module, arb_starve_ctr; all other logic is flat.

Verification
REQ-025 Display read only: disp_req=1, addr=0x040, mem_rdata=1 -> mem_en=1, mem_we=0 same cycle; disp_rvalid=1, disp_rdata=1 next cycle.
REQ-026 Engine write, no display: eng_req=1, we=1, addr=0x7FF, wdata=1 -> eng_gnt=1 same cycle, mem_we=1, mem_addr=0x7FF; eng_rvalid stays 0.
REQ-027 Both request at cycle 0: display served, eng_gnt=0; eng_req held; display drops at cycle 3 -> eng_gnt=1 at cycle 3; read data at cycle 4 on eng_rvalid.
REQ-028 Guard enabled, STARVE_MAX=7, disp_req and eng_req held high -> eng_gnt=1 and disp_drop=1 on every 8th cycle; guard disabled -> eng_gnt never rises.
REQ-029 Reset mid-read: disp read issued, rst_n=0 before the next edge -> disp_rvalid=0 and all outputs 0 during reset; no rvalid after release.
REQ-030 Idle: no requests for 10 cycles -> mem_en=0, mem_addr=0, all rvalid=0, counter=0.
